// File: rtl/i2c_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tx_arbiter
// Description : Round-robin arbiter sharing the I2C transmit FIFO write port
//               among NUM_REQ producers, with registered write outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 128,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pause,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      fifo_full,
    output logic                      write_enable,
    output logic [DATA_W-1:0]         write_data,
    output logic                      busy,
    output logic [CNT_W-1:0]          write_count
);

    localparam int              IDX_W      = $clog2(NUM_REQ);
    localparam logic [0:0]      S_IDLE     = 1'b0;
    localparam logic [0:0]      S_ISSUE    = 1'b1;
    localparam logic [IDX_W:0]  C_NUM_REQ  = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_REQ-1);

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_last;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_write_enable;
    logic               r_busy;
    logic [DATA_W-1:0]  r_write_data;
    logic [CNT_W-1:0]   r_write_count;

    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W:0]     w_sum;
    logic [DATA_W-1:0]  w_data;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_start;

    // Search from last+1 upward, wrapping; the first active request wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
            if (w_sum >= C_NUM_REQ) begin
                w_sum = w_sum - C_NUM_REQ;
            end
            if (!w_found && req[w_sum[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_grant = NUM_REQ'(1) << w_winner;
    assign w_start = (r_state == S_IDLE) && !pause && !fifo_full && w_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last         <= C_LAST_RST;
            r_grant        <= '0;
            r_write_enable <= 1'b0;
            r_busy         <= 1'b0;
            r_write_data   <= '0;
            r_write_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state        <= S_ISSUE;
                        r_last         <= w_winner;
                        r_grant        <= w_grant;
                        r_write_enable <= 1'b1;
                        r_busy         <= 1'b1;
                        r_write_data   <= w_data;
                    end
                end
                S_ISSUE: begin
                    // Write is committed regardless of pause/full/req changes now.
                    r_state        <= S_IDLE;
                    r_grant        <= '0;
                    r_write_enable <= 1'b0;
                    r_busy         <= 1'b0;
                    r_write_count  <= r_write_count + 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant        = r_grant;
    assign write_enable = r_write_enable;
    assign write_data   = r_write_data;
    assign busy         = r_busy;
    assign write_count  = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_i2c_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_tx_arbiter
// Description : Scoreboard bench for i2c_tx_arbiter using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         pause;
    logic [3:0]   req;
    logic [511:0] req_data;
    logic [3:0]   grant;
    logic         fifo_full;
    logic         write_enable;
    logic [127:0] write_data;
    logic         busy;
    logic [15:0]  write_count;

    i2c_tx_arbiter #(.NUM_REQ(4), .DATA_W(128), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .pause        (pause),
        .req          (req),
        .req_data     (req_data),
        .grant        (grant),
        .fifo_full    (fifo_full),
        .write_enable (write_enable),
        .write_data   (write_data),
        .busy         (busy),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   grant;
        logic [127:0] data;
        logic [15:0]  cnt;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    exp_t         m_e;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    logic [127:0] pat[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] g, input int slice, input logic [15:0] cnt, input int at);
        exp_t e;
        e.grant = g;
        e.data  = pat[slice];
        e.cnt   = cnt;
        e.cyc   = at;
        q.push_back(e);
    endtask

    // Monitor: every write strobe must match the next expected entry.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: grant=%b count=%0d at cycle %0d, required no write",
                         grant, write_count, cyc);
            end else begin
                m_e = q.pop_front();
                check("grant", 128'(grant), 128'(m_e.grant));
                check("write_data", write_data, m_e.data);
                check("count_before_write", 128'(write_count), 128'(m_e.cnt));
                check("busy_in_issue", 128'(busy), 128'(1'b1));
                check("write_cycle", 128'(cyc), 128'(m_e.cyc));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write_enable"}, 128'(write_enable), 128'(1'b0));
        check({tag, "_grant"}, 128'(grant), 128'(4'b0000));
        check({tag, "_busy"}, 128'(busy), 128'(1'b0));
        check({tag, "_write_data"}, write_data, 128'h0);
        check({tag, "_write_count"}, 128'(write_count), 128'(16'd0));
    endtask

    initial begin
        pat[0] = {16{8'h10}};
        pat[1] = {16{8'h21}};
        pat[2] = {16{8'hA5}};
        pat[3] = {16{8'h3C}};
        req_data  = {pat[3], pat[2], pat[1], pat[0]};
        rst       = 1'b1;
        pause     = 1'b0;
        req       = 4'b0000;
        fifo_full = 1'b0;

        // Reset, then a single request from requester 2
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        req = 4'b0100;
        push(4'b0100, 2, 16'd0, cyc + 1);
        tick();
        req = 4'b0000;
        tick(2);
        check("count_after_single", 128'(write_count), 128'(16'd1));

        // Fairness from a fresh reset: 0,1,2,3,0,1,2,3 on alternate cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            push(4'(1 << (i % 4)), i % 4, 16'(i), cyc + 1 + 2 * i);
        end
        tick(16);
        req = 4'b0000;
        tick(3);
        check("count_after_fairness", 128'(write_count), 128'(16'd8));

        // Backpressure: full stalls, release grants 0 then 1
        fifo_full = 1'b1;
        req       = 4'b0011;
        tick(10);
        push(4'b0001, 0, 16'd8, cyc + 1);
        push(4'b0010, 1, 16'd9, cyc + 3);
        fifo_full = 1'b0;
        tick();
        req = 4'b0010;
        tick(2);
        req = 4'b0000;
        tick(3);
        check("count_after_backpressure", 128'(write_count), 128'(16'd10));

        // Full rising during ISSUE: that write lands, nothing more while full
        req = 4'b0100;
        push(4'b0100, 2, 16'd10, cyc + 1);
        tick();
        fifo_full = 1'b1;
        tick(6);
        req       = 4'b0000;
        fifo_full = 1'b0;
        tick(2);
        check("count_after_full_in_issue", 128'(write_count), 128'(16'd11));

        // Pause, then withdraw before pause clears
        pause = 1'b1;
        req   = 4'b1000;
        tick(5);
        req = 4'b0000;
        tick();
        pause = 1'b0;
        tick(4);
        check("count_after_withdraw", 128'(write_count), 128'(16'd11));

        // Reset during ISSUE: write not counted, round robin restarts at 0
        req = 4'b0010;
        push(4'b0010, 1, 16'd11, cyc + 1);
        tick();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        check_reset_outputs("midwrite_reset");
        rst = 1'b0;
        req = 4'b1111;
        push(4'b0001, 0, 16'd0, cyc + 1);
        tick();
        req = 4'b0000;
        tick(3);
        check("count_after_restart", 128'(write_count), 128'(16'd1));

        check("pending_writes", 128'(q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
